pll_rst_ctrl: RTL and testbench

- Sequences the board PLL (`GTP_PLL_E3` wrapper) from the free-running 50 MHz reference clock.
- Drives the PLL reset and power-down pins, supervises `pll_lock`, and releases the system reset only after lock has been stable.
- On lock loss it reasserts system reset and restarts the PLL. After repeated lock timeouts it powers the PLL down and reports failure.
- Sits between the board reset pin, the PLL instance and the per-domain reset synchronisers.

---
 rtl/pll_rst_ctrl_pkg.sv | 13 +
 rtl/pll_rst_ctrl_sync_2ff.sv | 25 ++
 rtl/pll_rst_ctrl.sv | 116 +++++++++++
 tb/tb_pll_rst_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_ctrl_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings and retry counter width.
// The debug/CSR block decodes state_o with these same constants.
package pll_rst_ctrl_pkg;

    localparam int RETRY_W = 4;

    localparam logic [2:0] ST_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABILIZE = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

endpackage

// File: rtl/pll_rst_ctrl_sync_2ff.sv
// Generic two-flop synchroniser for slow asynchronous status bits (PLL lock and similar).
// Output lags the input by two clk edges and resets low.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset/power-down sequencer: pulses PLL reset, waits for stable lock, then releases
// the system reset; retries on lock timeout and parks the PLL powered down after MAX_RETRY.
module pll_rst_ctrl
    import pll_rst_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 7,
    parameter int CNT_W        = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_lock_i,
    input  logic                restart_i,
    output logic                pll_rst_o,
    output logic                pll_pwd_o,
    output logic                sys_rst_n_o,
    output logic                ready_o,
    output logic                fail_o,
    output logic [RETRY_W-1:0]  retry_cnt_o,
    output logic [2:0]          state_o
);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic               lock_s;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_pwd_q, sys_rst_n_q, ready_q, fail_q;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock wins over a coincident timeout.
                if (lock_s) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
                end
            end
            ST_STABILIZE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s || restart_i) state_d = ST_RESET_PLL;
            end
            ST_FAIL: begin
                if (restart_i) begin
                    state_d = ST_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
                retry_d = '0;
            end
        endcase
    end

    // The shared counter restarts on every state change, so each state measures its own dwell.
    assign cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            pll_pwd_q   <= 1'b0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == ST_RESET_PLL);
            pll_pwd_q   <= (state_d == ST_FAIL);
            sys_rst_n_q <= (state_d == ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign pll_pwd_o   = pll_pwd_q;
    assign sys_rst_n_o = sys_rst_n_q;
    assign ready_o     = ready_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scenario bench for pll_rst_ctrl with small timing parameters; expected output vectors
// and cycle counts are queued when stimulus is applied and compared when observed.
module tb_pll_rst_ctrl;

    localparam int W = 12;
    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_STAB  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       restart_i = 1'b0;
    logic       pll_rst_o, pll_pwd_o, sys_rst_n_o, ready_o, fail_o;
    logic [3:0] retry_cnt_o;
    logic [2:0] state_o;
    logic [W-1:0] dut_vec;

    int n_assert = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    int cnt_exp_q[$];

    pll_rst_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .LOCK_STABLE  (8),
        .MAX_RETRY    (2),
        .CNT_W        (17)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock_i  (pll_lock_i),
        .restart_i   (restart_i),
        .pll_rst_o   (pll_rst_o),
        .pll_pwd_o   (pll_pwd_o),
        .sys_rst_n_o (sys_rst_n_o),
        .ready_o     (ready_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {state_o, retry_cnt_o, pll_rst_o, pll_pwd_o, sys_rst_n_o, ready_o, fail_o};

    // Expected outputs for a given state and retry count.
    function automatic logic [W-1:0] model(input logic [2:0] st, input logic [3:0] rc);
        model = {st, rc, (st == S_RESET), (st == S_FAIL), (st == S_RUN), (st == S_RUN), (st == S_FAIL)};
    endfunction

    task automatic ticks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_for(input logic [2:0] st, input int budget, output int n);
        n = 0;
        while (state_o !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_width(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pll_rst_o === 1'b1 && n < budget);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        restart_i = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [W-1:0] e;
        int n, ce;
        pll_lock_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(model(S_RESET, 4'd0));
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t1_reset_vals: got %h exp %h", dut_vec, e); end
        ticks(2);
        rst_n = 1'b1;
        cnt_exp_q.push_back(4);
        pulse_width(20, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t1_pll_rst_width: got %0d exp %0d", n, ce); end
        ticks(6);
        pll_lock_i = 1'b1;
        cnt_exp_q.push_back(11);
        exp_q.push_back(model(S_RUN, 4'd0));
        wait_for(S_RUN, 40, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t1_lock_to_run: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t1_run_outs: got %h exp %h", dut_vec, e); end
    endtask

    task automatic test_timeout;
        logic [W-1:0] e;
        int n, ce;
        pll_lock_i = 1'b0;
        do_reset();
        pulse_width(20, n);
        cnt_exp_q.push_back(32);
        exp_q.push_back(model(S_RESET, 4'd1));
        wait_for(S_RESET, 100, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t2_timeout1_cycles: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t2_retry1_outs: got %h exp %h", dut_vec, e); end
        cnt_exp_q.push_back(4);
        pulse_width(20, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t2_second_pulse: got %0d exp %0d", n, ce); end
        cnt_exp_q.push_back(32);
        exp_q.push_back(model(S_FAIL, 4'd2));
        wait_for(S_FAIL, 100, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t2_timeout2_cycles: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t2_fail_outs: got %h exp %h", dut_vec, e); end
        ticks($urandom_range(3, 8));
        exp_q.push_back(model(S_FAIL, 4'd2));
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t2_fail_hold: got %h exp %h", dut_vec, e); end
        restart_i = 1'b1;
        ticks(1);
        restart_i = 1'b0;
        exp_q.push_back(model(S_RESET, 4'd0));
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t2_restart_outs: got %h exp %h", dut_vec, e); end
    endtask

    task automatic test_glitch;
        logic [W-1:0] e;
        int n, ce;
        pll_lock_i = 1'b0;
        do_reset();
        pulse_width(20, n);
        wait_for(S_RESET, 100, n);
        pll_lock_i = 1'b1;
        exp_q.push_back(model(S_STAB, 4'd1));
        wait_for(S_STAB, 40, n);
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t3_stab_outs: got %h exp %h", dut_vec, e); end
        // Glitch the pin so the synchronised lock is low while the window count is 5.
        ticks(3);
        pll_lock_i = 1'b0;
        ticks(1);
        pll_lock_i = 1'b1;
        cnt_exp_q.push_back(2);
        exp_q.push_back(model(S_WAIT, 4'd1));
        wait_for(S_WAIT, 10, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t3_glitch_cycles: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t3_glitch_outs: got %h exp %h", dut_vec, e); end
        cnt_exp_q.push_back(1);
        wait_for(S_STAB, 10, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t3_restab_cycles: got %0d exp %0d", n, ce); end
        cnt_exp_q.push_back(8);
        exp_q.push_back(model(S_RUN, 4'd0));
        wait_for(S_RUN, 20, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t3_run_cycles: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t3_run_outs: got %h exp %h", dut_vec, e); end
    endtask

    task automatic test_lock_loss;
        logic [W-1:0] e;
        int n, ce;
        pll_lock_i = 1'b0;
        cnt_exp_q.push_back(3);
        exp_q.push_back(model(S_RESET, 4'd0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sys_rst_n_o === 1'b1 && n < 10);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t4_loss_latency: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t4_loss_outs: got %h exp %h", dut_vec, e); end
        pll_lock_i = 1'b1;
        cnt_exp_q.push_back(13);
        exp_q.push_back(model(S_RUN, 4'd0));
        wait_for(S_RUN, 40, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t4_relock_cycles: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t4_relock_outs: got %h exp %h", dut_vec, e); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] e;
        int n, ce, hi;
        pll_lock_i = 1'b0;
        ticks(2);
        restart_i = 1'b1;
        ticks(1);
        restart_i = 1'b0;
        exp_q.push_back(model(S_RESET, 4'd0));
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t5_collide_outs: got %h exp %h", dut_vec, e); end
        cnt_exp_q.push_back(4);
        pulse_width(20, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t5_collide_width: got %0d exp %0d", n, ce); end
        cnt_exp_q.push_back(0);
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (pll_rst_o !== 1'b0) hi++;
        end
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (hi != ce) begin n_fail++; $display("FAIL t5_extra_pulse: got %0d exp %0d", hi, ce); end
        restart_i = 1'b1;
        ticks(1);
        restart_i = 1'b0;
        exp_q.push_back(model(S_WAIT, 4'd0));
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t5_wait_restart_ignored: got %h exp %h", dut_vec, e); end
        cnt_exp_q.push_back(26);
        exp_q.push_back(model(S_RESET, 4'd1));
        wait_for(S_RESET, 100, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t5_timeout_cont: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t5_timeout_outs: got %h exp %h", dut_vec, e); end
    endtask

    task automatic test_async_reset;
        logic [W-1:0] e;
        int n, ce;
        pll_lock_i = 1'b1;
        do_reset();
        wait_for(S_STAB, 40, n);
        ticks(2);
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(model(S_RESET, 4'd0));
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t6_stab_async: got %h exp %h", dut_vec, e); end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_width(20, n);
        cnt_exp_q.push_back(9);
        wait_for(S_RUN, 40, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t6_rerun1_cycles: got %0d exp %0d", n, ce); end
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(model(S_RESET, 4'd0));
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t6_run_async: got %h exp %h", dut_vec, e); end
        @(negedge clk);
        rst_n = 1'b1;
        cnt_exp_q.push_back(4);
        pulse_width(20, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t6_rerun_width: got %0d exp %0d", n, ce); end
        cnt_exp_q.push_back(9);
        exp_q.push_back(model(S_RUN, 4'd0));
        wait_for(S_RUN, 40, n);
        ce = cnt_exp_q.pop_front(); n_assert++;
        if (n != ce) begin n_fail++; $display("FAIL t6_rerun2_cycles: got %0d exp %0d", n, ce); end
        e = exp_q.pop_front(); n_assert++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL t6_rerun_outs: got %h exp %h", dut_vec, e); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_glitch();
        test_lock_loss();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_assert);
        $fatal(1, "watchdog expired");
    end

endmodule
